// File: rtl/bram_loader.sv
// Burst loader: streams in_valid/in_ready words into a 2^AW x DW memory, with a registered read port.
// Define BRAM_LOADER_CHECKSUM_EN to add the chk output (XOR of all words accepted in the burst).
module bram_loader #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
`ifdef BRAM_LOADER_CHECKSUM_EN
    ,
    output logic [DW-1:0] chk
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_len;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_ptr;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic          w_accept;
    logic          w_last;
    logic          w_start;

    assign w_start  = (r_state == ST_IDLE) && start;
    assign w_accept = (r_state == ST_LOAD) && in_valid;
    // The beat that brings the count up to the latched length ends the burst.
    assign w_last   = w_accept && ((r_count + (AW+1)'(1)) == r_len);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_LOAD;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst length, write pointer and accepted-word count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len   <= '0;
            r_count <= '0;
            r_ptr   <= '0;
        end else if (w_start) begin
            r_len   <= len;
            r_count <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_count <= r_count + (AW+1)'(1);
            r_ptr   <= r_ptr + AW'(1);
        end
    end

    // Memory write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (w_accept && !reset) begin
            r_mem[r_ptr] <= in_data;
        end
    end

    // Registered read port; a colliding write is seen only on the following read
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [DW-1:0] r_chk;

    // Running XOR of accepted words, restarted on each start
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chk <= '0;
        end else if (w_start) begin
            r_chk <= '0;
        end else if (w_accept) begin
            r_chk <= r_chk ^ in_data;
        end
    end

    assign chk = r_chk;
`endif

    assign in_ready = (r_state == ST_LOAD);
    assign busy     = (r_state == ST_LOAD);
    assign done     = (r_state == ST_DONE);
    assign wr_count = r_count;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_bram_loader.sv
// Randomized scoreboard bench for bram_loader: an array memory model plus queued done/readback expectations.
module tb_bram_loader;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [DW-1:0] chk;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] m_mem [256];
    bit            m_written [256];
    int            exp_done_q [$];
    logic [DW-1:0] exp_chk_q [$];
    logic [DW-1:0] exp_rd_q [$];
    logic [DW-1:0] burst_data [$];
    bit            rd_issue = 1'b0;
    bit            rd_pend  = 1'b0;

    always #5 clock = ~clock;

    bram_loader #(.AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
`ifdef BRAM_LOADER_CHECKSUM_EN
        ,
        .chk      (chk)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // A read issued before an edge is due on the following negedge
    always @(posedge clock) rd_pend <= rd_issue;

    always @(negedge clock) begin
        if (rd_pend) begin
            if (exp_rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
            else check("rd_data", rd_data, exp_rd_q.pop_front());
        end
        if (done) begin
            if (exp_done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                check("wr_count_at_done", wr_count, exp_done_q.pop_front());
`ifdef BRAM_LOADER_CHECKSUM_EN
                if (exp_chk_q.size() == 0) check("chk_q_underflow", 32'd1, 32'd0);
                else check("chk_at_done", chk, exp_chk_q.pop_front());
`endif
            end
        end
    end

    task automatic issue_read_random();
        int a;
        a = $urandom_range(0, 255);
        if (m_written[a] && ($urandom_range(0, 1) == 1)) begin
            rd_addr  = 8'(a);
            exp_rd_q.push_back(m_mem[a]);
            rd_issue = 1'b1;
        end else begin
            rd_issue = 1'b0;
        end
    endtask

    task automatic read_sweep(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            rd_addr  = 8'(a);
            exp_rd_q.push_back(m_mem[a]);
            rd_issue = 1'b1;
            tick();
        end
        rd_issue = 1'b0;
        tick();
    endtask

    // gap_mode: 0 = always valid, 1 = valid on alternate cycles, 2 = random gaps
    task automatic run_burst(input int L, input int gap_mode, input bit poke_start);
        int            cnt = 0;
        int            cyc = 0;
        int            ptr = 0;
        logic [DW-1:0] x   = '0;
        logic [DW-1:0] d;
        for (int i = 0; i < L; i++) x ^= burst_data[i];
        exp_done_q.push_back(L);
        exp_chk_q.push_back(x);
        start    = 1'b1;
        len      = 9'(L);
        rd_issue = 1'b0;
        tick();
        start = 1'b0;
        while (cnt < L) begin
            check("in_ready_load", in_ready, 32'd1);
            check("busy_load", busy, 32'd1);
            check("wr_count_progress", wr_count, cnt);
            case (gap_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0) || (cyc > 8 * L + 16);
            endcase
            if (poke_start) begin
                start = 1'($urandom_range(0, 1));
                len   = 9'($urandom_range(1, 300));
            end
            issue_read_random();
            if (in_valid) begin
                d       = burst_data.pop_front();
                in_data = d;
                m_mem[ptr]     = d;
                m_written[ptr] = 1'b1;
                ptr++;
                cnt++;
            end else begin
                in_data = 8'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        rd_issue = 1'b0;
        start    = poke_start;
        len      = 9'd5;
        check("done_after_last", done, 32'd1);
        check("ready_low_in_done", in_ready, 32'd0);
        check("busy_low_in_done", busy, 32'd0);
        check("wr_count_in_done", wr_count, L);
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 32'd0);
        check("wr_count_hold", wr_count, L);
        if (poke_start) begin
            tick();
            check("start_in_done_ignored", busy, 32'd0);
        end
    endtask

    task automatic run_reset_abort();
        int ptr = 0;
        burst_data = {8'h5A, 8'hC3, 8'h77, 8'h88, 8'h99};
        start = 1'b1;
        len   = 9'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = burst_data.pop_front();
            m_mem[ptr]     = in_data;
            m_written[ptr] = 1'b1;
            ptr++;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        burst_data.delete();
        check("abort_wr_count", wr_count, 32'd0);
        check("abort_busy", busy, 32'd0);
        check("abort_ready", in_ready, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
`ifdef BRAM_LOADER_CHECKSUM_EN
        check("abort_chk", chk, 32'd0);
`endif
        for (int i = 0; i < 4; i++) tick();
        read_sweep(0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_checks++;
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int L;
        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_addr  = '0;
        tick();
        tick();
        check("reset_busy", busy, 32'd0);
        check("reset_done", done, 32'd0);
        check("reset_wr_count", wr_count, 32'd0);
        check("reset_ready", in_ready, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        reset = 1'b0;
        tick();

        burst_data = {8'h11, 8'h22, 8'h33, 8'h44};
        run_burst(4, 0, 1'b0);
        read_sweep(0, 3);

        burst_data = {8'hA1, 8'hB2, 8'hC3};
        run_burst(3, 1, 1'b0);

        for (int i = 0; i < 256; i++) burst_data.push_back(8'(i) ^ 8'hA5);
        run_burst(256, 0, 1'b0);
        read_sweep(0, 255);

        burst_data.delete();
        run_burst(0, 0, 1'b0);
        check("zero_len_no_overwrite", 32'(m_mem[0]), 32'h000000A5);
        read_sweep(0, 1);

        for (int i = 0; i < 6; i++) burst_data.push_back(8'($urandom));
        run_burst(6, 2, 1'b1);

        run_reset_abort();

        burst_data = {8'h0F, 8'hF0, 8'hFF};
        run_burst(3, 0, 1'b0);
        burst_data = {8'h12};
        run_burst(1, 2, 1'b0);

        for (int b = 0; b < 6; b++) begin
            L = $urandom_range(1, 20);
            for (int i = 0; i < L; i++) burst_data.push_back(8'($urandom));
            run_burst(L, 2, 1'b0);
        end
        read_sweep(0, 20);

        for (int i = 0; i < 4; i++) tick();
        check("done_q_drained", exp_done_q.size(), 32'd0);
        check("rd_q_drained", exp_rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter AW, default 8, address width; memory depth is 2^AW words.
REQ-002 SHALL have parameter DW, default 8, data word width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a load burst; sampled only in IDLE.
REQ-006 SHALL have port len  input  AW+1  number of words to load (0..2^AW); sampled with start.
REQ-007 SHALL have port in_valid  input  1  write-side data valid.
REQ-008 SHALL have port in_ready  output  1  write-side ready.
REQ-009 SHALL have port in_data  input  DW  write-side data word.
REQ-010 SHALL have port busy  output  1  high while in LOAD.
REQ-011 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-012 SHALL have port wr_count  output  AW+1  words accepted in the current or last burst.
REQ-013 SHALL have port rd_addr  input  AW  read-port address.
REQ-014 SHALL have port rd_data  output  DW  read-port data, registered.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-016 SHALL, in IDLE with start=1 and len!=0: latch len, clear write pointer and wr_count, go to LOAD.
REQ-017 SHALL, in IDLE with start=1 and len=0: clear wr_count and go directly to DONE; memory is not written.
REQ-018 SHALL ignore start in LOAD and DONE.
REQ-019 SHALL drive in_ready=1 only in LOAD, combinationally from state.
REQ-020 SHALL accept a word only on a cycle where in_valid=1 and in_ready=1.
REQ-021 SHALL write each accepted word to mem[pointer], then increment pointer and wr_count by 1.
REQ-022 SHALL, when the accepted word makes wr_count equal the latched len, go to DONE on the next edge.
REQ-023 SHALL, for len=2^AW, write addresses 0..2^AW-1 exactly once; the pointer wraps to 0 only at completion.
REQ-024 SHALL hold in_ready low for DONE's single cycle, drive done=1 there, then return to IDLE.
REQ-025 SHALL allow a new start on the first IDLE cycle after DONE; bursts are back-to-back at most every len+2 cycles.
REQ-026 SHALL tolerate arbitrary in_valid gaps; the pointer and wr_count advance only on accepted beats.
REQ-027 SHALL give rd_data = mem[rd_addr] with exactly one clock of latency, independent of FSM state.
REQ-028 SHALL, on a same-cycle read and write to one address, return the old (pre-write) data.
REQ-029 SHALL hold wr_count after DONE until the next start.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set state IDLE, pointer 0, wr_count 0, busy 0, done 0, rd_data 0.
REQ-031 SHALL abort a LOAD on reset; words written before reset remain in memory, and no done pulse is produced.
REQ-032 SHALL not initialise memory contents on reset.

Configuration
REQ-033 SHALL, with BRAM_LOADER_CHECKSUM_EN defined, add output chk (DW bits), the XOR of all words accepted since the last start.
REQ-034 SHALL clear chk on the IDLE start edge and reset it to 0; chk is final and stable from the DONE cycle until the next start.
REQ-035 SHALL, with BRAM_LOADER_CHECKSUM_EN undefined, omit chk and all checksum logic; all other behaviour is unchanged.

Verification
REQ-036 SHALL cover a basic load: start with len=4, in_valid held high with data 0x11,0x22,0x33,0x44 -> done one cycle after the 4th beat, wr_count=4; then read addr 0..3 -> 0x11,0x22,0x33,0x44 one cycle after each address.
REQ-037 SHALL cover backpressure gaps: len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 writes, done on the cycle after the 5th beat, wr_count=3.
REQ-038 SHALL cover a full sweep: len=256, data=addr^0xA5 -> done after 256 beats; an 8-bit address sweep from 0 reads back addr^0xA5 with one-cycle latency.
REQ-039 SHALL cover a zero-length burst and ignored start: len=0 -> done next cycle with no in_ready; start asserted during LOAD -> no effect on len or wr_count.
REQ-040 SHALL cover reset mid-load: reset after 2 of 5 beats -> IDLE, wr_count=0, no done pulse; addresses 0,1 hold written data.
REQ-041 SHALL cover the checksum (macro defined): load 0x0F,0xF0,0xFF -> chk=0x00 at DONE; load 0x12 -> chk=0x12.
